mpu_matrix_loader: RTL and testbench

- Upstream stage of the MPU addition datapath.
- Accepts a serial stream of 8-bit elements over a valid/ready handshake.
- Assembles two 5x5 operand matrices, A then B, and presents both in parallel to the addition stage.
- Holds the operands stable until the consumer acknowledges them.

---
 rtl/mpu_matrix_loader_if.sv | 27 ++
 rtl/mpu_matrix_loader.sv | 102 ++++++++++
 tb/tb_mpu_matrix_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_matrix_loader_if.sv
// Handshake and operand bus between the element stream source, the matrix loader
// and the addition stage.
interface mpu_matrix_loader_if #(
  parameter int unsigned DIM   = 5,
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     abort;
  logic [DIM*DIM*WIDTH-1:0] matrix_a;
  logic [DIM*DIM*WIDTH-1:0] matrix_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [4:0]               load_index;
  logic                     loading_b;

  modport slave (
    input  in_data, in_valid, abort, out_ready,
    output in_ready, matrix_a, matrix_b, out_valid, load_index, loading_b
  );

  modport master (
    output in_data, in_valid, abort, out_ready,
    input  in_ready, matrix_a, matrix_b, out_valid, load_index, loading_b
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Serial-to-parallel loader for the two MPU addition operands (A then B).
// Optional MPU_LOADER_TRANSPOSE_B_EN: B stream is stored column-major.
module mpu_matrix_loader #(
  parameter int unsigned DIM   = 5,
  parameter int unsigned WIDTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  mpu_matrix_loader_if.slave bus
);
  localparam int unsigned NELEM = DIM * DIM;
  localparam logic [4:0]  LAST  = 5'(NELEM - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [4:0]       r_idx;
  logic [WIDTH-1:0] r_a [NELEM];
  logic [WIDTH-1:0] r_b [NELEM];

  logic       w_in_ready;
  logic       w_accept;
  logic       w_last;
  logic       w_we_a;
  logic       w_we_b;
  logic [4:0] w_b_slot;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_idx == LAST);

  always_ff @(posedge clock) begin
    if (reset) r_state <= LOAD_A;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD_A: begin
        if (bus.abort)                w_state_next = LOAD_A;
        else if (w_accept && w_last)  w_state_next = LOAD_B;
      end
      LOAD_B: begin
        if (bus.abort)                w_state_next = LOAD_A;
        else if (w_accept && w_last)  w_state_next = FULL;
      end
      FULL: begin
        if (bus.abort || bus.out_ready) w_state_next = LOAD_A;
      end
      default: w_state_next = LOAD_A;
    endcase
  end

  // in_ready is gated by reset combinationally so nothing is taken during reset.
  always_comb begin
    w_in_ready    = (r_state != FULL) && !reset;
    bus.out_valid = (r_state == FULL);
    bus.loading_b = (r_state == LOAD_B);
    w_we_a        = w_accept && !bus.abort && (r_state == LOAD_A);
    w_we_b        = w_accept && !bus.abort && (r_state == LOAD_B);
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.load_index = r_idx;

`ifdef MPU_LOADER_TRANSPOSE_B_EN
  int unsigned w_k;
  always_comb begin
    w_k      = 32'(r_idx);
    w_b_slot = 5'((w_k % DIM) * DIM + (w_k / DIM));
  end
`else
  assign w_b_slot = r_idx;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx <= '0;
    end else if (bus.abort && (r_state != FULL)) begin
      r_idx <= '0;
    end else if (w_we_a || w_we_b) begin
      r_idx <= w_last ? '0 : r_idx + 5'd1;
    end
  end

  // Operand storage is only cleared by reset; abort and consumption leave it intact.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a <= '{default: '0};
      r_b <= '{default: '0};
    end else begin
      if (w_we_a) r_a[r_idx]    <= bus.in_data;
      if (w_we_b) r_b[w_b_slot] <= bus.in_data;
    end
  end

  for (genvar g = 0; g < NELEM; g++) begin : g_pack
    assign bus.matrix_a[g*WIDTH +: WIDTH] = r_a[g];
    assign bus.matrix_b[g*WIDTH +: WIDTH] = r_b[g];
  end
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader against a stream-count reference model.
module tb_mpu_matrix_loader;
  localparam int N = 25;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mpu_matrix_loader_if #(.DIM(5), .WIDTH(8)) bus ();

  mpu_matrix_loader #(.DIM(5), .WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: count of accepted elements in the current pair, and a full flag.
  int         m_n    = 0;
  bit         m_full = 1'b0;
  logic [7:0] exp_a [N];
  logic [7:0] exp_b [N];

  function automatic int bslot(input int k);
`ifdef MPU_LOADER_TRANSPOSE_B_EN
    return (k % 5) * 5 + k / 5;
`else
    return k;
`endif
  endfunction

  function automatic void model_edge(input logic v, input logic [7:0] d, input logic ab,
                                     input logic ordy, input logic rst);
    if (rst) begin
      for (int i = 0; i < N; i++) begin exp_a[i] = 8'h00; exp_b[i] = 8'h00; end
      m_n = 0; m_full = 1'b0;
    end else if (m_full) begin
      if (ab || ordy) m_full = 1'b0;
    end else if (ab) begin
      m_n = 0;
    end else if (v) begin
      if (m_n < N) exp_a[m_n] = d;
      else         exp_b[bslot(m_n - N)] = d;
      m_n++;
      if (m_n == 2 * N) begin m_n = 0; m_full = 1'b1; end
    end
  endfunction

  function automatic logic [7:0] exp_status();
    logic [4:0] idx;
    idx = 5'(m_n % N);
    return {!m_full && !reset, m_full, (m_n >= N), idx};
  endfunction

  function automatic logic [199:0] pack_a();
    logic [199:0] p;
    for (int i = 0; i < N; i++) p[i*8 +: 8] = exp_a[i];
    return p;
  endfunction

  function automatic logic [199:0] pack_b();
    logic [199:0] p;
    for (int i = 0; i < N; i++) p[i*8 +: 8] = exp_b[i];
    return p;
  endfunction

  function automatic logic [7:0] elem(input logic [199:0] m, input int r, input int c);
    return m[(r*5 + c)*8 +: 8];
  endfunction

  function automatic logic [7:0] dut_status();
    return {bus.in_ready, bus.out_valid, bus.loading_b, bus.load_index};
  endfunction

  // One clock: drive at negedge, model the rising edge, land on the next negedge.
  task automatic step(input logic v, input logic [7:0] d, input logic ab,
                      input logic ordy, input logic rst);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.abort     = ab;
    bus.out_ready = ordy;
    reset         = rst;
    model_edge(v, d, ab, ordy, rst);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut_status() !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_status: got %b want %b", dut_status(), 8'b1000_0000);
    end
    n_checks++;
    if (bus.matrix_a !== '0 || bus.matrix_b !== '0) begin
      n_err++; $display("FAIL reset_matrices: got a=%h b=%h want zero", bus.matrix_a, bus.matrix_b);
    end
  endtask

  task automatic test_stream();
    int rise = 0;
    for (int k = 0; k < 2 * N; k++) begin
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_err++; $display("FAIL stream_ready k=%0d: got %b want 1", k, bus.in_ready);
      end
      step(1'b1, 8'(k + 1), 1'b0, 1'b0, 1'b0);
      if (bus.out_valid === 1'b1 && rise == 0) rise = k + 1;
      n_checks++;
      if (dut_status() !== exp_status()) begin
        n_err++; $display("FAIL stream_status k=%0d: got %b want %b", k, dut_status(), exp_status());
      end
    end
    n_checks++;
    if (rise != 2 * N) begin
      n_err++; $display("FAIL stream_latency: out_valid after %0d accepts, want 50", rise);
    end
    n_checks++;
    if (elem(bus.matrix_a, 0, 0) !== 8'd1 || elem(bus.matrix_a, 4, 4) !== 8'd25) begin
      n_err++; $display("FAIL stream_a_corners: got %0d,%0d want 1,25",
                        elem(bus.matrix_a, 0, 0), elem(bus.matrix_a, 4, 4));
    end
`ifdef MPU_LOADER_TRANSPOSE_B_EN
    n_checks++;
    if (elem(bus.matrix_b, 0, 1) !== 8'd31 || elem(bus.matrix_b, 1, 0) !== 8'd27) begin
      n_err++; $display("FAIL stream_b_transpose: got %0d,%0d want 31,27",
                        elem(bus.matrix_b, 0, 1), elem(bus.matrix_b, 1, 0));
    end
`else
    n_checks++;
    if (elem(bus.matrix_b, 0, 0) !== 8'd26 || elem(bus.matrix_b, 2, 3) !== 8'd39) begin
      n_err++; $display("FAIL stream_b_elems: got %0d,%0d want 26,39",
                        elem(bus.matrix_b, 0, 0), elem(bus.matrix_b, 2, 3));
    end
`endif
    n_checks++;
    if (bus.matrix_a !== pack_a() || bus.matrix_b !== pack_b()) begin
      n_err++; $display("FAIL stream_matrices: got a=%h b=%h want a=%h b=%h",
                        bus.matrix_a, bus.matrix_b, pack_a(), pack_b());
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_status() !== 8'b0100_0000) begin
        n_err++; $display("FAIL hold_status c=%0d: got %b want %b", c, dut_status(), 8'b0100_0000);
      end
      n_checks++;
      if (bus.matrix_a !== pack_a() || bus.matrix_b !== pack_b()) begin
        n_err++; $display("FAIL hold_matrices c=%0d: got a=%h b=%h", c, bus.matrix_a, bus.matrix_b);
      end
    end
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL hold_release: got valid=%b ready=%b want 0,1", bus.out_valid, bus.in_ready);
    end
    n_checks++;
    if (bus.matrix_a !== pack_a() || bus.matrix_b !== pack_b()) begin
      n_err++; $display("FAIL hold_keep: got a=%h b=%h", bus.matrix_a, bus.matrix_b);
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 12; k++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.load_index !== 5'd12) begin
      n_err++; $display("FAIL abort_pre_idx: got %0d want 12", bus.load_index);
    end
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dut_status() !== 8'b1000_0000) begin
      n_err++; $display("FAIL abort_status: got %b want %b", dut_status(), 8'b1000_0000);
    end
    n_checks++;
    if (bus.matrix_a !== pack_a()) begin
      n_err++; $display("FAIL abort_a: got %h want %h", bus.matrix_a, pack_a());
    end
    for (int k = 0; k < 2 * N; k++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.matrix_a !== pack_a() || bus.matrix_b !== pack_b()) begin
      n_err++; $display("FAIL abort_reload: got valid=%b a=%h b=%h want a=%h b=%h",
                        bus.out_valid, bus.matrix_a, bus.matrix_b, pack_a(), pack_b());
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dut_status() !== 8'b1000_0000) begin
      n_err++; $display("FAIL abort_full: got %b want %b", dut_status(), 8'b1000_0000);
    end
  endtask

  task automatic test_reset_mid_b();
    for (int k = 0; k < N + 7; k++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.load_index !== 5'd7 || bus.loading_b !== 1'b1) begin
      n_err++; $display("FAIL midb_pre: got idx=%0d lb=%b want 7,1", bus.load_index, bus.loading_b);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL midb_ready_gate: got %b want 0", bus.in_ready);
    end
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dut_status() !== 8'b1000_0000) begin
      n_err++; $display("FAIL midb_status: got %b want %b", dut_status(), 8'b1000_0000);
    end
    n_checks++;
    if (bus.matrix_a !== '0 || bus.matrix_b !== '0) begin
      n_err++; $display("FAIL midb_clear: got a=%h b=%h want zero", bus.matrix_a, bus.matrix_b);
    end
  endtask

  task automatic test_random();
    logic       v, ab, ordy;
    logic [7:0] d;
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 9) >= 3);
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        2: d = 8'h80;
        default: d = 8'($urandom_range(0, 255));
      endcase
      ab   = ($urandom_range(0, 79) == 0);
      ordy = ($urandom_range(0, 2) == 0);
      step(v, d, ab, ordy, 1'b0);
      n_checks++;
      if (dut_status() !== exp_status()) begin
        n_err++; $display("FAIL rand_status c=%0d: got %b want %b", c, dut_status(), exp_status());
      end
      if (m_full) begin
        n_checks++;
        if (bus.matrix_a !== pack_a() || bus.matrix_b !== pack_b()) begin
          n_err++; $display("FAIL rand_matrices c=%0d: got a=%h b=%h want a=%h b=%h",
                            c, bus.matrix_a, bus.matrix_b, pack_a(), pack_b());
        end
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_abort();
    test_reset_mid_b();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
